uart_cmd_parser: RTL

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_pkg.sv | 5 +
 rtl/uart_frame_timer.sv | 16 +
 rtl/uart_cmd_parser.sv | 75 +++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared frame constants and FSM state encodings for the UART command link
package uart_cmd_pkg;
  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  typedef enum logic [2:0] {IDLE, ADDR, DHI, DLO, CHK} state_t;
endpackage

// File: rtl/uart_frame_timer.sv
// uart_frame_timer: inter-byte idle watchdog, expires after TIMEOUT enabled cycles without a clear
module uart_frame_timer #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic clk_50m,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [15:0] cnt;
  // Count cycles while enabled; a clear restarts the idle window
  always_ff @(posedge clk_50m)
    cnt <= (rst || clear) ? 16'd0 : enable ? cnt + 16'd1 : cnt;
  assign expired = enable && cnt == TIMEOUT - 16'd1;
endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes HEADER/ADDR/DATA_HI/DATA_LO/CHK byte frames into register writes
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  HEADER  = HEADER_DEFAULT,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        busy
);
  state_t      state_q, state_d;
  logic [7:0]  sum_q, addr_q;
  logic [15:0] data_q;
  logic        expired, wr_en_d, err_d;
  uart_frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_50m(clk_50m),
    .rst(rst),
    .clear(rx_done || state_q == IDLE),
    .enable(state_q != IDLE),
    .expired(expired)
  );
  assign busy = state_q != IDLE;
  // Next state and strobe decisions; a byte arriving on the timeout cycle wins over the timeout
  always_comb begin
    wr_en_d = rx_done && state_q == CHK && rx_data == sum_q;
    err_d   = (rx_done && state_q == CHK && rx_data != sum_q) || (!rx_done && expired);
    state_d = rx_done ? (state_q == IDLE ? (rx_data == HEADER ? ADDR : IDLE) :
                         state_q == ADDR ? DHI :
                         state_q == DHI  ? DLO :
                         state_q == DLO  ? CHK : IDLE)
                      : expired ? IDLE : state_q;
  end
  // State register
  always_ff @(posedge clk_50m)
    state_q <= rst ? IDLE : state_d;
  // Frame capture and running checksum; the sum restarts on every byte seen in IDLE
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      sum_q  <= 8'h00;
      addr_q <= 8'h00;
      data_q <= 16'h0000;
    end else if (rx_done) begin
      sum_q <= state_q == IDLE ? 8'h00 : sum_q + rx_data;
      if (state_q == ADDR) addr_q <= rx_data;
      if (state_q == DHI) data_q[15:8] <= rx_data;
      if (state_q == DLO) data_q[7:0] <= rx_data;
    end
  end
  // Registered write/error strobes, held write payload and saturating error count
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 16'h0000;
      err_cnt   <= 8'h00;
    end else begin
      wr_en     <= wr_en_d;
      frame_err <= err_d;
      if (wr_en_d) begin
        wr_addr <= addr_q;
        wr_data <= data_q;
      end
      if (err_d && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
endmodule
